iterative_mac_execute: RTL

//  RISC-MGMT custom-extension execute stage. Implements multi-cycle R-type MUL / MAC / RDACC.

---
 rtl/iterative_mac_execute.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/iterative_mac_execute.sv
// Iterative shift-add MUL / MAC / RDACC execute stage for the custom-extension port.
// A multiply retires BITS_PER_CYCLE multiplier bits per CALC cycle. The result is held
// in DONE until the core accepts the write-back. A persistent accumulator backs MAC and RDACC.
module iterative_mac_execute #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SATURATE       = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [4:0]       rd,
    input  logic             stall,
    input  logic             flush,
    output logic             busy,
    output logic             reg_w,
    output logic [WIDTH-1:0] reg_wdata,
    output logic [4:0]       reg_rd,
    output logic             exception,
    output logic             branch_jump
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_RDACC = 2'b10;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] prod_q,   prod_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [4:0]       rd_q,     rd_d;
    logic [1:0]       op_q,     op_d;

    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] prod_next;
    logic             accept;

    // Accumulator add: the carry out either wraps or clamps to all-ones.
    function automatic logic [WIDTH-1:0] acc_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if ((SATURATE != 0) && s[WIDTH]) begin
            return '1;
        end
        return s[WIDTH-1:0];
    endfunction

    // One shift-add step: the low multiplier slice times the shifted multiplicand, truncated to WIDTH.
    always_comb begin
        partial   = a_q * WIDTH'(b_q[BITS_PER_CYCLE-1:0]);
        prod_next = prod_q + partial;
    end

    // Next-state logic for the FSM, the datapath registers and the accumulator.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        result_d  = result_q;
        count_d   = count_q;
        rd_d      = rd_q;
        op_d      = op_q;
        busy      = 1'b0;
        exception = 1'b0;
        accept    = start && (state_q == IDLE) && !flush;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((op == OP_MUL) || (op == OP_MAC)) begin
                        a_d     = rs1_data;
                        b_d     = rs2_data;
                        rd_d    = rd;
                        op_d    = op;
                        count_d = CNT_W'(N);
                        prod_d  = '0;
                        state_d = CALC;
                        busy    = 1'b1;
                    end else if (op == OP_RDACC) begin
                        result_d = acc_q;
                        rd_d     = rd;
                        op_d     = op;
                        state_d  = DONE;
                    end else begin
                        exception = 1'b1;
                    end
                end
            end
            CALC: begin
                busy    = 1'b1;
                prod_d  = prod_next;
                a_d     = a_q << BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    result_d = (op_q == OP_MAC) ? acc_add(acc_q, prod_next) : prod_next;
                end
            end
            DONE: begin
                // Commit happens only on the cycle the core takes the write-back.
                if (!stall) begin
                    state_d = IDLE;
                    if (op_q == OP_MAC) begin
                        acc_d = result_q;
                    end else if (op_q == OP_RDACC) begin
                        acc_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush kills whatever is in flight and never touches the accumulator.
        if (flush) begin
            state_d = IDLE;
            acc_d   = acc_q;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            rd_q     <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            op_q     <= op_d;
        end
    end

    // Write-back outputs are presented only while the result is held in DONE.
    always_comb begin
        reg_w       = (state_q == DONE);
        reg_wdata   = reg_w ? result_q : '0;
        reg_rd      = rd_q;
        branch_jump = 1'b0;
    end

endmodule
